mem_copy_dma: RTL
=================

# mem_copy_dma

Bus initiator that copies a block of words from a source to a destination region over one req/gnt/rvalid memory port. It is the master counterpart of the single-port RAM responder, sits between a control register block and on-chip RAM, and keeps at most one transaction outstanding. Typical uses are boot-image relocation and buffer moves without core involvement.

## Interface
- ADDR_WIDTH, 8, byte-address width on the memory port.
- DATA_WIDTH, 32, data width; a multiple of 8.
- LEN_WIDTH, 8, width of the word-count input.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start_i  in  1  launches a copy; ignored while busy_o=1.
- abort_i  in  1  stops the copy after the current word completes.
- src_addr_i  in  ADDR_WIDTH  source byte address, sampled on start.
- dst_addr_i  in  ADDR_WIDTH  destination byte address, sampled on start.
- len_i  in  LEN_WIDTH  word count, sampled on start.
- busy_o  out  1  copy in progress.
- done_o  out  1  one-cycle pulse when a copy ends (normal, aborted, or zero-length).
- port_req_o  out  1  request.
- port_addr_o  out  ADDR_WIDTH  byte address.
- port_we_o  out  1  1 = write, 0 = read.
- port_wdata_o  out  DATA_WIDTH  write data.
- en_o  out  1  memory enable; equal to port_req_o.
- be_o  out  DATA_WIDTH/8  byte enables; all ones on writes, all zeros on reads.
- port_gnt_i  in  1  grant.
- port_rvalid_i  in  1  response valid, for both reads and writes.
- port_rdata_i  in  DATA_WIDTH  read data, qualified by port_rvalid_i.

## Operation
- States:
  - IDLE: waits for start.
  - RD_REQ: issues the read request.
  - RD_WAIT: waits for the read response.
  - WR_REQ: issues the write request.
  - WR_WAIT: waits for the write response.
  - DONE: emits the done pulse.
- IDLE, start_i=1:
  - Latch src, dst and len.
  - If len=0, go to DONE. Otherwise go to RD_REQ.
- RD_REQ / WR_REQ:
  - Drive port_req_o=1 with address, we, wdata and be held stable until the cycle port_gnt_i=1.
  - On grant, move to the matching WAIT state.
- RD_WAIT: on port_rvalid_i, capture port_rdata_i into the data register and go to WR_REQ.
- WR_WAIT: on port_rvalid_i:
  - Advance src and dst by DATA_WIDTH/8. Addresses wrap modulo 2^ADDR_WIDTH; no error is raised.
  - Decrement the remaining-word count.
  - Go to DONE if the count reaches 0 or an abort is pending. Otherwise go to RD_REQ.
- abort_i:
  - Is sticky until DONE.
  - Never cuts a granted transaction; the in-flight word completes its read and its write.
  - An abort seen in IDLE is ignored.
- DONE: done_o=1 for one cycle, then IDLE.
- Rvalid received outside a WAIT state is ignored.
- start_i while busy is dropped; it is not queued.
- Reset mid-copy returns to IDLE immediately. The partial copy is not resumed.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- port_req_o is registered and is driven from state only. It never depends combinationally on port_gnt_i.
- With zero-wait grant (gnt in the same cycle as req) and rvalid one cycle later, a copy takes 4 cycles per word:
  - start_i sampled at edge 0.
  - Word k read request in cycle 1+4k; write request in cycle 3+4k.
  - busy_o=1 in cycles 1..4N.
  - done_o=1 in cycle 4N+1, with busy_o=0 in that cycle.
- len=0: done_o in cycle 1; no bus activity.
- Each cycle of grant stall or rvalid delay adds exactly one cycle to the total.

## Structure
- Package mem_copy_pkg holds the state enum mem_copy_state_e and the word-size constant localparam WORD_BYTES = DATA_WIDTH/8 (helper function).
- Single module. No sub-module is warranted; the address/count datapath is about 30 lines.

## Test plan
- Copy src=0x00, dst=0x40, len=4 against a zero-latency RAM model preloaded with 0x11111111..0x44444444:
  - Words 0x40..0x4C match the source.
  - done_o in cycle 17.
  - busy_o high in cycles 1–16.
- len=0 -> done_o in cycle 1; port_req_o never asserted.
- Random grant stalls of 0–3 cycles, len=8:
  - Data is correct.
  - Address, we and wdata stay stable while req=1 and gnt=0.
  - Cycle count = 33 plus the total stall cycles.
- abort_i pulsed during the write request of word 1 of len=5:
  - Words 0–1 are written; words 2–4 are untouched.
  - done_o pulses once.
- src=0xF8, dst=0x00, len=3 (ADDR_WIDTH=8): reads 0xF8, 0xFC, 0x00 — wrap-around with no error.
- rst_n asserted mid-copy:
  - All outputs are 0 asynchronously.
  - A later start with len=1 completes normally in 5 cycles.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and word-size helper for the memory copy initiator.
package mem_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } mem_copy_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int WORD_BYTES = DEFAULT_DATA_WIDTH / 8;

  function automatic int word_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Block copy initiator: read word, write word, repeat, over one req/gnt/rvalid port.
// Port handshake: a request is held (req, addr, we, wdata, be stable) until the
// cycle gnt=1; exactly one response per granted request arrives later as rvalid=1.
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    port_req_o,
  output logic [ADDR_WIDTH-1:0]   port_addr_o,
  output logic                    port_we_o,
  output logic [DATA_WIDTH-1:0]   port_wdata_o,
  output logic                    en_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic                    port_gnt_i,
  input  logic                    port_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   port_rdata_i,
  output mem_copy_state_e         state_o
);

  localparam int STEP = word_bytes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STEP);

  mem_copy_state_e        state;
  logic [ADDR_WIDTH-1:0]  src_q;
  logic [ADDR_WIDTH-1:0]  dst_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic                   abort_pend;

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      abort_pend   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      port_req_o   <= 1'b0;
      port_addr_o  <= '0;
      port_we_o    <= 1'b0;
      port_wdata_o <= '0;
      en_o         <= 1'b0;
      be_o         <= '0;
    end else begin
      done_o <= 1'b0;
      // Abort only matters while a copy is running; it is cleared on the way out.
      if (abort_i && state != ST_IDLE && state != ST_DONE)
        abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            src_q <= src_addr_i;
            dst_q <= dst_addr_i;
            cnt_q <= len_i;
            if (len_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state       <= ST_RD_REQ;
              busy_o      <= 1'b1;
              port_req_o  <= 1'b1;
              en_o        <= 1'b1;
              port_we_o   <= 1'b0;
              be_o        <= '0;
              port_addr_o <= src_addr_i;
            end
          end
        end
        ST_RD_REQ: begin
          if (port_gnt_i) begin
            state      <= ST_RD_WAIT;
            port_req_o <= 1'b0;
            en_o       <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          // The write-data output doubles as the data register.
          if (port_rvalid_i) begin
            state        <= ST_WR_REQ;
            port_wdata_o <= port_rdata_i;
            port_req_o   <= 1'b1;
            en_o         <= 1'b1;
            port_we_o    <= 1'b1;
            be_o         <= '1;
            port_addr_o  <= dst_q;
          end
        end
        ST_WR_REQ: begin
          if (port_gnt_i) begin
            state      <= ST_WR_WAIT;
            port_req_o <= 1'b0;
            en_o       <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (port_rvalid_i) begin
            src_q     <= src_q + ADDR_STEP;
            dst_q     <= dst_q + ADDR_STEP;
            cnt_q     <= cnt_q - LEN_WIDTH'(1);
            port_we_o <= 1'b0;
            be_o      <= '0;
            if (cnt_q == LEN_WIDTH'(1) || abort_pend || abort_i) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state       <= ST_RD_REQ;
              port_req_o  <= 1'b1;
              en_o        <= 1'b1;
              port_addr_o <= src_q + ADDR_STEP;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          abort_pend <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
